// File: rtl/load_store_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : load_store_unit                                                  |
// | Brief   : Memory stage of load/store instructions. Builds byte enables and |
// |           replicated write data, and extracts and extends load data. The   |
// |           core is stalled from request acceptance until memory responds.   |
// | Options : MISALIGN_TRAP_EN - trap misaligned H/HU/W accesses instead of    |
// |           issuing them (misalign_o pulses, no memory request is made).     |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module load_store_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              core_req_i,
    input  logic              core_we_i,
    input  logic [2:0]        core_size_i,
    input  logic [ADDR_W-1:0] core_addr_i,
    input  logic [31:0]       core_wd_i,
    output logic [31:0]       core_rd_o,
    output logic              core_stall_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [3:0]        mem_be_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wd_o,
    input  logic [31:0]       mem_rd_i,
    input  logic              mem_ready_i,
    output logic              misalign_o
);

    // Size codes as produced by the main decoder
    localparam logic [2:0] c_ldst_b  = 3'b000;
    localparam logic [2:0] c_ldst_h  = 3'b001;
    localparam logic [2:0] c_ldst_bu = 3'b100;
    localparam logic [2:0] c_ldst_hu = 3'b101;

    // FSM state encoding
    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_req  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    logic [1:0]        r_state;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [3:0]        r_mem_be;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_wd;
    logic [31:0]       r_core_rd;
    logic [2:0]        r_size;
    logic [1:0]        r_off;
    logic              r_misalign;

    logic [1:0]        w_off;
    logic [3:0]        w_be;
    logic [31:0]       w_wd;
    logic [7:0]        w_ld_byte;
    logic [15:0]       w_ld_half;
    logic [31:0]       w_ld;
    logic              w_misalign;
    logic              w_stall;

    assign w_off = core_addr_i[1:0];

    // Byte-lane enables and replicated store data for the incoming request;
    // undefined size codes fall through to the full-word case
    always_comb begin
        w_be = 4'b1111;
        w_wd = core_wd_i;
        case (core_size_i)
            c_ldst_b, c_ldst_bu: begin
                w_be = 4'b0001 << w_off;
                w_wd = {4{core_wd_i[7:0]}};
            end
            c_ldst_h, c_ldst_hu: begin
                w_be = 4'b0011 << {w_off[1], 1'b0};
                w_wd = {2{core_wd_i[15:0]}};
            end
            default: begin
                w_be = 4'b1111;
                w_wd = core_wd_i;
            end
        endcase
    end

    // Lane extraction and sign/zero extension of the returned memory word,
    // driven by the size/offset captured at acceptance
    always_comb begin
        w_ld_byte = mem_rd_i[7:0];
        case (r_off)
            2'd0:    w_ld_byte = mem_rd_i[7:0];
            2'd1:    w_ld_byte = mem_rd_i[15:8];
            2'd2:    w_ld_byte = mem_rd_i[23:16];
            default: w_ld_byte = mem_rd_i[31:24];
        endcase
        w_ld_half = r_off[1] ? mem_rd_i[31:16] : mem_rd_i[15:0];
        w_ld      = mem_rd_i;
        case (r_size)
            c_ldst_b:  w_ld = {{24{w_ld_byte[7]}}, w_ld_byte};
            c_ldst_bu: w_ld = {24'h000000, w_ld_byte};
            c_ldst_h:  w_ld = {{16{w_ld_half[15]}}, w_ld_half};
            c_ldst_hu: w_ld = {16'h0000, w_ld_half};
            default:   w_ld = mem_rd_i;
        endcase
    end

`ifdef MISALIGN_TRAP_EN
    // Halfwords need an even address, words need a word-aligned address
    always_comb begin
        w_misalign = 1'b0;
        case (core_size_i)
            c_ldst_b, c_ldst_bu: w_misalign = 1'b0;
            c_ldst_h, c_ldst_hu: w_misalign = w_off[0];
            default:             w_misalign = (w_off != 2'b00);
        endcase
    end
`else
    // No alignment check: low address bits only select lanes
    assign w_misalign = 1'b0;
`endif

    // Request sequencing: accept in IDLE, hold the port in REQ until ready,
    // then one DONE cycle with the stall released so the core retires
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= c_st_idle;
            r_mem_req  <= 1'b0;
            r_mem_we   <= 1'b0;
            r_mem_be   <= 4'b0000;
            r_mem_addr <= '0;
            r_mem_wd   <= 32'h0000_0000;
            r_core_rd  <= 32'h0000_0000;
            r_size     <= 3'b000;
            r_off      <= 2'b00;
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (core_req_i) begin
                        if (w_misalign) begin
                            r_misalign <= 1'b1;
                            r_state    <= c_st_done;
                        end else begin
                            r_mem_req  <= 1'b1;
                            r_mem_we   <= core_we_i;
                            r_mem_be   <= w_be;
                            r_mem_addr <= core_addr_i;
                            r_mem_wd   <= w_wd;
                            r_size     <= core_size_i;
                            r_off      <= w_off;
                            r_state    <= c_st_req;
                        end
                    end
                end
                c_st_req: begin
                    if (mem_ready_i) begin
                        r_mem_req <= 1'b0;
                        if (!r_mem_we) begin
                            r_core_rd <= w_ld;
                        end
                        r_state <= c_st_done;
                    end
                end
                c_st_done: begin
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state   <= c_st_idle;
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

    // Stall follows the request while idle, holds through REQ, and is forced
    // low while reset is asserted
    always_comb begin
        w_stall = 1'b0;
        case (r_state)
            c_st_idle: w_stall = core_req_i;
            c_st_req:  w_stall = 1'b1;
            default:   w_stall = 1'b0;
        endcase
    end

    assign core_stall_o = w_stall & rst_ni;
    assign core_rd_o    = r_core_rd;
    assign mem_req_o    = r_mem_req;
    assign mem_we_o     = r_mem_we;
    assign mem_be_o     = r_mem_be;
    assign mem_addr_o   = r_mem_addr;
    assign mem_wd_o     = r_mem_wd;
    assign misalign_o   = r_misalign;

endmodule
`default_nettype wire
